gs_update: RTL and testbench
============================

Name: gs_update

Overview:
- Row-update datapath of the 16-unknown banded Gauss-Seidel solver. Sits directly downstream of the x/b register file.
- Each cycle it consumes one row's b and six neighbour x values and computes x_new = (b + 13(x1+x2) − 6(x3+x4) + (x5+x6)) / 20. Diagonal is 20; off-diagonals at ±1, ±2, ±3 are −13, +6, −1.
- 3-stage pipeline. Tracks row and sweep position and flags completion after NUM_ITER sweeps.

Parameters:
- N, 16: rows per sweep; row_out wraps at N−1.
- NUM_ITER, 16: sweeps before done_out.
- RECIP, 838861: round(2^RECIP_SHIFT / 20), unsigned 20-bit.
- RECIP_SHIFT, 24: right shift applied after the reciprocal multiply.

Ports:
- clk_in  input  1  clock; all state updates on its rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- clear_in  input  1  synchronous flush: drops in-flight rows, zeroes counters.
- valid_in  input  1  row operands valid this cycle.
- b_in  input  16  b of current row, signed integer.
- x1_in, x2_in  input  32 each  x[i+1], x[i−1]; signed Q16.16 (register file supplies zero outside the matrix).
- x3_in, x4_in  input  32 each  x[i+2], x[i−2]; signed Q16.16.
- x5_in, x6_in  input  32 each  x[i+3], x[i−3]; signed Q16.16.
- valid_out  output  1  x_out valid.
- x_out  output  32  updated x, signed Q16.16.
- row_out  output  4  row index of x_out.
- sweep_out  output  4  sweep index of x_out.
- done_out  output  1  one-cycle pulse with the final row of the final sweep.

Behaviour:
- Reset (rst_in=1 at an edge): all pipeline valids 0. valid_out, x_out, row_out, sweep_out, done_out = 0. Data registers = 0. Dominates clear_in and valid_in.
- clear_in=1 (without reset): same effect as reset on valids and counters. A valid_in in the same cycle is discarded.
- Stage 1, registered:
  - bq = sign-extended b_in << 16, 40-bit signed.
  - s12 = x1+x2, s34 = x3+x4, s56 = x5+x6, each 33-bit signed, sign-extended.
- Stage 2: acc = bq + 13·s12 − 6·s34 + s56, 40-bit signed. Cannot overflow (|acc| < 2^38).
- Stage 3:
  - p = acc · RECIP, 60-bit signed.
  - r = (p + 2^(RECIP_SHIFT−1)) >>> RECIP_SHIFT, arithmetic shift: round half toward +∞.
  - Saturate r to [0x80000000, 0x7FFFFFFF] and register as x_out.
- Latency: valid_in at edge t gives valid_out at edge t+3. Throughput 1 row/cycle. No back-pressure; bubbles pass through.
- x_out holds its last value while valid_out=0.
- Row/sweep counters advance only on a cycle that outputs valid_out=1:
  - row_out = index of that result, starting at 0.
  - Internal row counter increments after each valid output and wraps N−1→0.
  - On wrap, sweep counter increments.
- done_out=1 together with the valid_out of row N−1 in sweep NUM_ITER−1. On the next edge both counters return to 0; the block re-arms for a new solve.
- Valid output while done is pulsing: counters still restart at 0 afterwards, no extra done.
- Simultaneous clear_in and final-row output: clear wins; done_out is not asserted.

Decomposition:
- Shared package gs_pkg holds:
  - widths: B_W=16, X_W=32, FRAC=16, ACC_W=40;
  - matrix coefficients C0=20, C1=13, C2=6, C3=1;
  - RECIP and RECIP_SHIFT defaults;
  - N_ROWS=16.
- One natural sub-module: gs_div20_sat. Stage 3: reciprocal multiply, rounding, saturation, output register.
- Counters and done logic stay in gs_update.

Test Plan:
- Reset mid-stream: rst_in asserted with 2 rows in flight → next cycle valid_out=0, x_out=0, row_out=0, sweep_out=0; no late outputs appear.
- Unit solve: b_in=20, all x=0, one valid pulse at cycle t → valid_out at t+3, x_out=0x00010000. Same with b_in=−20 → 0xFFFF0000.
- Coefficient check: b_in=0, x1=x2=0x00010000, others 0 → x_out=0x00014CCD. x3=0x00010000 alone → 0xFFFFB333. x5=0x00010000 alone → 0x00000CCD.
- Saturation: b_in=32767, x1=x2=0x7FFFFFFF, x3=x4=0x80000000 → x_out=0x7FFFFFFF. Mirrored signs with b_in=−32768 → 0x80000000.
- Sweep/done: 256 back-to-back valid rows with NUM_ITER=16 → row_out cycles 0..15; sweep_out 0..15; done_out high exactly once, on output 256. Next output reports row 0, sweep 0.
- Bubbles and clear: valid_in pattern 1,0,1,1 → valid_out 1,0,1,1 three cycles later with rows 0,1,2. clear_in asserted during the cycle a valid_out would otherwise appear → it is suppressed; next output is row 0, sweep 0.

Source files
------------

// File: rtl/gs_pkg.sv
// Shared widths, matrix coefficients and divider constants for the
// banded Gauss-Seidel row-update datapath.
package gs_pkg;

    localparam int B_W   = 16;  // b operand, signed integer
    localparam int X_W   = 32;  // x operand, signed Q16.16
    localparam int FRAC  = 16;  // fractional bits of x
    localparam int ACC_W = 40;  // stage-2 accumulator
    localparam int S_W   = X_W + 1;  // pairwise neighbour sum

    // Banded matrix: diagonal C0, off-diagonals -C1 (+-1), +C2 (+-2), -C3 (+-3)
    localparam int C0 = 20;
    localparam int C1 = 13;
    localparam int C2 = 6;
    localparam int C3 = 1;

    // Reciprocal of the diagonal, rounded to nearest: 838861 for a 24-bit shift
    localparam int RECIP_SHIFT_DEF = 24;
    localparam int RECIP_DEF       = ((1 << RECIP_SHIFT_DEF) + C0 / 2) / C0;

    localparam int N_ROWS = 16;

    // Stage-1 register contents
    typedef struct packed {
        logic signed [ACC_W-1:0] bq;   // b scaled into Q16.16
        logic signed [S_W-1:0]   s12;  // x[i+1] + x[i-1]
        logic signed [S_W-1:0]   s34;  // x[i+2] + x[i-2]
        logic signed [S_W-1:0]   s56;  // x[i+3] + x[i-3]
    } s1_t;

    // Sign-extend a pairwise sum to accumulator width
    function automatic logic signed [ACC_W-1:0] sx_sum(input logic [S_W-1:0] v);
        return {{(ACC_W - S_W){v[S_W-1]}}, v};
    endfunction

endpackage

// File: rtl/gs_div20_sat.sv
// Final stage: divide the accumulator by the diagonal via reciprocal
// multiply, round half toward +inf, saturate to Q16.16 and register.
// The product is registered once before rounding, so this block adds two
// cycles of latency; prod_valid marks the cycle before valid_out rises.
module gs_div20_sat
    import gs_pkg::*;
#(
    parameter int RECIP       = RECIP_DEF,
    parameter int RECIP_SHIFT = RECIP_SHIFT_DEF
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    clear_in,
    input  logic                    acc_valid,
    input  logic signed [ACC_W-1:0] acc,
    output logic                    prod_valid,
    output logic                    valid_out,
    output logic [X_W-1:0]          x_out
);

    localparam int P_W = 60;
    localparam logic signed [P_W-1:0] RECIP_X = P_W'(RECIP);
    localparam logic signed [P_W-1:0] HALF    = P_W'(1) << (RECIP_SHIFT - 1);
    localparam logic signed [P_W-1:0] SAT_MAX = P_W'(32'h7FFF_FFFF);
    localparam logic signed [P_W-1:0] SAT_MIN = -SAT_MAX - P_W'(1);

    logic signed [P_W-1:0] acc_x;
    logic signed [P_W-1:0] prod_d;
    logic signed [P_W-1:0] prod_q;
    logic signed [P_W-1:0] rnd;
    logic signed [P_W-1:0] shr;
    logic [X_W-1:0]        sat_d;

    // Reciprocal multiply; |acc| < 2^38 keeps the product well inside 60 bits
    always_comb begin
        acc_x  = {{(P_W - ACC_W){acc[ACC_W-1]}}, acc};
        prod_d = acc_x * RECIP_X;
    end

    // Round half up, arithmetic shift, clamp to the signed 32-bit range
    always_comb begin
        rnd = prod_q + HALF;
        shr = rnd >>> RECIP_SHIFT;
        if (shr > SAT_MAX) begin
            sat_d = SAT_MAX[X_W-1:0];
        end else if (shr < SAT_MIN) begin
            sat_d = SAT_MIN[X_W-1:0];
        end else begin
            sat_d = shr[X_W-1:0];
        end
    end

    // Product register and output register; clear drops both valids
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            prod_valid <= 1'b0;
            prod_q     <= '0;
            valid_out  <= 1'b0;
            x_out      <= '0;
        end else begin
            prod_valid <= acc_valid & ~clear_in;
            if (acc_valid) begin
                prod_q <= prod_d;
            end
            valid_out <= prod_valid & ~clear_in;
            if (prod_valid & ~clear_in) begin
                x_out <= sat_d;
            end
        end
    end

endmodule

// File: rtl/gs_update.sv
// Row-update datapath of the banded Gauss-Seidel solver:
//   x_new = (b + 13(x1+x2) - 6(x3+x4) + (x5+x6)) / 20
// Handshake: valid_in qualifies all row operands in the cycle it is high;
// there is no ready, every valid row is accepted, and valid_out pulses
// exactly three edges later with x_out, row_out, sweep_out and done_out.
// Bubbles propagate unchanged; clear_in flushes all in-flight rows.
module gs_update
    import gs_pkg::*;
#(
    parameter int N           = N_ROWS,
    parameter int NUM_ITER    = 16,
    parameter int RECIP       = RECIP_DEF,
    parameter int RECIP_SHIFT = RECIP_SHIFT_DEF
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           clear_in,
    input  logic           valid_in,
    input  logic [B_W-1:0] b_in,
    input  logic [X_W-1:0] x1_in,
    input  logic [X_W-1:0] x2_in,
    input  logic [X_W-1:0] x3_in,
    input  logic [X_W-1:0] x4_in,
    input  logic [X_W-1:0] x5_in,
    input  logic [X_W-1:0] x6_in,
    output logic           valid_out,
    output logic [X_W-1:0] x_out,
    output logic [3:0]     row_out,
    output logic [3:0]     sweep_out,
    output logic           done_out
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] ROW_LAST   = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] SWEEP_LAST = CNT_W'(NUM_ITER - 1);
    localparam logic signed [ACC_W-1:0] K1 = ACC_W'(C1);
    localparam logic signed [ACC_W-1:0] K2 = ACC_W'(C2);
    localparam logic signed [ACC_W-1:0] K3 = ACC_W'(C3);

    s1_t                     s1_d;
    s1_t                     s1_q;
    logic                    v1_q;
    logic                    v2_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] acc_q;
    logic                    take;
    logic                    prod_valid;
    logic [CNT_W-1:0]        row_cnt;
    logic [CNT_W-1:0]        sweep_cnt;
    logic                    last_row;

    assign take     = valid_in & ~clear_in;
    assign last_row = (row_cnt == ROW_LAST) && (sweep_cnt == SWEEP_LAST);

    // Stage-1 operands: scale b into Q16.16, pair neighbours symmetrically
    always_comb begin
        s1_d     = '0;
        s1_d.bq  = {{(ACC_W - B_W - FRAC){b_in[B_W-1]}}, b_in, {FRAC{1'b0}}};
        s1_d.s12 = {x1_in[X_W-1], x1_in} + {x2_in[X_W-1], x2_in};
        s1_d.s34 = {x3_in[X_W-1], x3_in} + {x4_in[X_W-1], x4_in};
        s1_d.s56 = {x5_in[X_W-1], x5_in} + {x6_in[X_W-1], x6_in};
    end

    // Stage 1 register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            v1_q <= 1'b0;
            s1_q <= '0;
        end else begin
            v1_q <= take;
            if (take) begin
                s1_q <= s1_d;
            end
        end
    end

    // Stage-2 weighted sum of the band (off-diagonal signs folded in)
    always_comb begin
        acc_d = s1_q.bq
              + sx_sum(s1_q.s12) * K1
              - sx_sum(s1_q.s34) * K2
              + sx_sum(s1_q.s56) * K3;
    end

    // Stage 2 register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            v2_q  <= 1'b0;
            acc_q <= '0;
        end else begin
            v2_q <= v1_q & ~clear_in;
            if (v1_q) begin
                acc_q <= acc_d;
            end
        end
    end

    gs_div20_sat #(
        .RECIP       (RECIP),
        .RECIP_SHIFT (RECIP_SHIFT)
    ) u_div20_sat (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .clear_in   (clear_in),
        .acc_valid  (v2_q),
        .acc        (acc_q),
        .prod_valid (prod_valid),
        .valid_out  (valid_out),
        .x_out      (x_out)
    );

    // Row/sweep tracking: tag each result as it is registered, re-arm after done
    always_ff @(posedge clk_in) begin
        if (rst_in || clear_in) begin
            row_cnt   <= '0;
            sweep_cnt <= '0;
            row_out   <= '0;
            sweep_out <= '0;
            done_out  <= 1'b0;
        end else if (prod_valid) begin
            row_out   <= row_cnt;
            sweep_out <= sweep_cnt;
            done_out  <= last_row;
            if (last_row) begin
                row_cnt   <= '0;
                sweep_cnt <= '0;
            end else if (row_cnt == ROW_LAST) begin
                row_cnt   <= '0;
                sweep_cnt <= sweep_cnt + 1'b1;
            end else begin
                row_cnt <= row_cnt + 1'b1;
            end
        end else begin
            done_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gs_update.sv
// Bench for gs_update: fixed vectors with exact-latency checks, hand-built
// reset/clear/bubble/done sequences, and randomized rows scored against an
// arithmetic reference model by an output monitor.
module tb_gs_update;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        clear_in = 1'b0;
    logic        valid_in = 1'b0;
    logic [15:0] b_in = '0;
    logic [31:0] x1_in = '0, x2_in = '0, x3_in = '0, x4_in = '0, x5_in = '0, x6_in = '0;
    logic        valid_out;
    logic [31:0] x_out;
    logic [3:0]  row_out;
    logic [3:0]  sweep_out;
    logic        done_out;

    int n_checks = 0;
    int n_fail = 0;
    int out_k = 0;       // index of the next expected output within a solve
    int done_seen = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        string       name;
        logic [15:0] b;
        logic [31:0] x1, x2, x3, x4, x5, x6;
        logic [31:0] exp_x;
    } vec_t;
    vec_t vt[7];

    gs_update dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear_in  (clear_in),
        .valid_in  (valid_in),
        .b_in      (b_in),
        .x1_in     (x1_in),
        .x2_in     (x2_in),
        .x3_in     (x3_in),
        .x4_in     (x4_in),
        .x5_in     (x5_in),
        .x6_in     (x6_in),
        .valid_out (valid_out),
        .x_out     (x_out),
        .row_out   (row_out),
        .sweep_out (sweep_out),
        .done_out  (done_out)
    );

    // Clock and watchdog
    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact rational formula, divide by reciprocal, round half up, clamp
    function automatic logic [31:0] model_x(input logic [15:0] b,
                                            input logic [31:0] a1, input logic [31:0] a2,
                                            input logic [31:0] a3, input logic [31:0] a4,
                                            input logic [31:0] a5, input logic [31:0] a6);
        longint acc, p, r;
        acc = longint'($signed(b)) * 65536
            + 13 * (longint'($signed(a1)) + longint'($signed(a2)))
            - 6 * (longint'($signed(a3)) + longint'($signed(a4)))
            + (longint'($signed(a5)) + longint'($signed(a6)));
        p = acc * 838861;
        r = (p + 64'sd8388608) >>> 24;
        if (r > 64'sh7FFF_FFFF) r = 64'sh7FFF_FFFF;
        else if (r < -64'sh8000_0000) r = -64'sh8000_0000;
        return r[31:0];
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [15:0] b,
                        input logic [31:0] a1, input logic [31:0] a2,
                        input logic [31:0] a3, input logic [31:0] a4,
                        input logic [31:0] a5, input logic [31:0] a6);
        valid_in = 1'b1;
        b_in = b;
        x1_in = a1; x2_in = a2; x3_in = a3; x4_in = a4; x5_in = a5; x6_in = a6;
        exp_q.push_back(model_x(b, a1, a2, a3, a4, a5, a6));
        tick();
        valid_in = 1'b0;
    endtask

    task automatic send_rand();
        send(16'($urandom()), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom());
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        valid_in = 1'b0;
        tick();
        exp_q.delete();
        out_k = 0;
        rst_in = 1'b0;
    endtask

    task automatic do_clear();
        clear_in = 1'b1;
        valid_in = 1'b0;
        tick();
        exp_q.delete();
        out_k = 0;
        clear_in = 1'b0;
    endtask

    // Scoreboard monitor: every valid output must match the model and counter tags
    always @(negedge clk_in) begin
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mon_unexpected: output %0h with no pending row, expected none", x_out);
            end else begin
                check("mon_x", x_out, exp_q.pop_front());
                check("mon_row", row_out, out_k % 16);
                check("mon_sweep", sweep_out, (out_k / 16) % 16);
                check("mon_done", done_out, (out_k % 256) == 255);
                if (done_out === 1'b1) done_seen++;
                out_k = (out_k + 1) % 256;
            end
        end else if (done_out === 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL mon_done_no_valid: done_out=1, expected 0 without valid_out");
        end
    end

    initial begin
        logic [3:0] pat;
        int         row_e;

        vt[0] = '{"unit_pos",  16'd20,     32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0001_0000};
        vt[1] = '{"unit_neg",  16'hFFEC,   32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_0000};
        vt[2] = '{"coef_c1",   16'd0,      32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0001_4CCD};
        vt[3] = '{"coef_c2",   16'd0,      32'h0, 32'h0, 32'h0001_0000, 32'h0, 32'h0, 32'h0, 32'hFFFF_B333};
        vt[4] = '{"coef_c3",   16'd0,      32'h0, 32'h0, 32'h0, 32'h0, 32'h0001_0000, 32'h0, 32'h0000_0CCD};
        vt[5] = '{"sat_pos",   16'h7FFF,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                  32'h0, 32'h0, 32'h7FFF_FFFF};
        vt[6] = '{"sat_neg",   16'h8000,   32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                  32'h0, 32'h0, 32'h8000_0000};

        // Reset state
        rst_in = 1'b1;
        tick();
        tick();
        do_reset();
        check("rst_valid", valid_out, 0);
        check("rst_x", x_out, 0);
        check("rst_row", row_out, 0);
        check("rst_sweep", sweep_out, 0);
        check("rst_done", done_out, 0);

        // Fixed vectors, single pulses with exact latency
        for (int i = 0; i < 7; i++) begin
            send(vt[i].b, vt[i].x1, vt[i].x2, vt[i].x3, vt[i].x4, vt[i].x5, vt[i].x6);
            tick();
            tick();
            check({vt[i].name, "_early"}, valid_out, 0);
            tick();
            check({vt[i].name, "_valid"}, valid_out, 1);
            check({vt[i].name, "_x"}, x_out, vt[i].exp_x);
        end

        // Reset with two rows in flight
        send_rand();
        send_rand();
        rst_in = 1'b1;
        tick();
        exp_q.delete();
        out_k = 0;
        rst_in = 1'b0;
        check("rstmid_valid", valid_out, 0);
        check("rstmid_x", x_out, 0);
        check("rstmid_row", row_out, 0);
        check("rstmid_sweep", sweep_out, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rstmid_no_late", valid_out, 0);
        end

        // Bubbles: pattern 1,0,1,1 must reappear three edges later
        pat = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            if (pat[i]) send_rand();
            else idle(1);
        end
        row_e = 0;
        for (int j = 0; j < 4; j++) begin
            check("bubble_valid", valid_out, pat[j]);
            if (pat[j]) begin
                check("bubble_row", row_out, row_e);
                row_e++;
            end
            tick();
        end
        idle(3);

        // Clear suppresses the output it coincides with and drops a same-cycle valid
        send_rand();
        send_rand();
        send_rand();
        idle(2);
        clear_in = 1'b1;
        valid_in = 1'b1;
        b_in = 16'd20;
        tick();
        exp_q.delete();
        out_k = 0;
        clear_in = 1'b0;
        valid_in = 1'b0;
        check("clear_suppress", valid_out, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("clear_drop", valid_out, 0);
        end
        send_rand();
        idle(3);
        check("clear_next_valid", valid_out, 1);
        check("clear_next_row", row_out, 0);
        check("clear_next_sweep", sweep_out, 0);

        // Random rows with random bubbles, scored by the monitor
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) send_rand();
            else idle(1);
        end
        idle(4);

        // Full solve: 256 back-to-back rows, done on the last one only
        do_clear();
        done_seen = 0;
        for (int i = 0; i < 256; i++) send_rand();
        idle(3);
        check("done_valid", valid_out, 1);
        check("done_pulse", done_out, 1);
        check("done_row", row_out, 15);
        check("done_sweep", sweep_out, 15);
        send_rand();
        idle(3);
        check("rearm_row", row_out, 0);
        check("rearm_sweep", sweep_out, 0);
        check("rearm_done", done_out, 0);
        check("done_count", done_seen, 1);

        // Clear coinciding with the final row of the final sweep
        do_clear();
        for (int i = 0; i < 256; i++) send_rand();
        idle(2);
        clear_in = 1'b1;
        tick();
        exp_q.delete();
        out_k = 0;
        clear_in = 1'b0;
        check("clrdone_valid", valid_out, 0);
        check("clrdone_done", done_out, 0);
        idle(4);
        check("clrdone_count", done_seen, 1);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
